sprite_ram_loader: RTL and testbench

SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

---
 rtl/tank_gfx_pkg.sv | 31 +++
 rtl/sprite_xy_counter.sv | 71 +++++++
 rtl/sprite_ram_loader.sv | 188 ++++++++++++++++++
 tb/tb_sprite_ram_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_gfx_pkg.sv
// -----------------------------------------------------------------------------
// tank_gfx_pkg
// Shared definitions for the sprite graphics blocks: default RAM geometry,
// the transparent colour key, sprite dimension widths and the loader FSM
// state encoding.
// -----------------------------------------------------------------------------
package tank_gfx_pkg;

    // Default sprite RAM geometry.
    localparam int unsigned SPRITE_ADDR_W = 19;
    localparam int unsigned SPRITE_DATA_W = 24;

    // Pixels equal to this key are treated as transparent by the renderer.
    // The loader stores them verbatim; it never interprets pixel values.
    localparam logic [23:0] TRANSPARENT_KEY = 24'hFF0000;

    // Sprite dimension counters (width_px / height_px / x / y).
    localparam int unsigned   DIM_W          = 10;
    localparam logic [DIM_W-1:0] DIM_ONE     = DIM_W'(1);

    // Largest legal row pitch exponent (pitch = 2^width_log2 words).
    localparam logic [3:0]    MAX_WIDTH_LOG2 = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } loader_state_e;

endpackage

// File: rtl/sprite_xy_counter.sv
// -----------------------------------------------------------------------------
// sprite_xy_counter
// Raster position counter for a sprite being streamed in row-major order.
//
// Ports
//   Clk       : clock, rising edge
//   Reset     : synchronous active-high reset, zeroes x and y
//   step      : advance one pixel (x++, wrapping to the next row)
//   clear     : restart at (0,0); has priority over step
//   width_px  : pixels per row
//   height_px : rows in the sprite
//   x, y      : current pixel position
//   last      : current position is the final pixel of the sprite
// -----------------------------------------------------------------------------
module sprite_xy_counter
    import tank_gfx_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             step,
    input  logic             clear,
    input  logic [DIM_W-1:0] width_px,
    input  logic [DIM_W-1:0] height_px,
    output logic [DIM_W-1:0] x,
    output logic [DIM_W-1:0] y,
    output logic             last
);

    logic [DIM_W-1:0] x_q, x_d;
    logic [DIM_W-1:0] y_q, y_d;
    logic             row_end;

    always_comb begin
        // NOTE: every signal gets a default at the top of the block so no
        // path leaves it unassigned, which would infer a latch.
        x_d     = x_q;
        y_d     = y_q;
        row_end = (x_q == width_px - DIM_ONE);

        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (step) begin
            if (row_end) begin
                x_d = '0;
                y_d = y_q + DIM_ONE;
            end else begin
                x_d = x_q + DIM_ONE;
            end
        end
    end

    // NOTE: reset is synchronous: it is tested inside the clocked block and
    // has no entry in the sensitivity list.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples its input before any of them changes.
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = row_end && (y_q == height_px - DIM_ONE);

endmodule

// File: rtl/sprite_ram_loader.sv
// -----------------------------------------------------------------------------
// sprite_ram_loader
// Copies a streamed sprite into sprite RAM. Pixels arrive in raster order on a
// valid/ready handshake; each accepted pixel at (x,y) is written one cycle
// later to base_addr + x + (y << width_log2).
//
// Ports
//   Clk, Reset        : clock (rising edge), synchronous active-high reset
//   start             : one-cycle load request, honoured only when idle
//   base_addr         : first RAM word of the sprite
//   width_log2        : row pitch exponent (pitch = 2^width_log2 words)
//   width_px          : pixels per row
//   height_px         : number of rows
//   pix_data/pix_valid: incoming pixel stream
//   pix_ready         : loader accepts a pixel this cycle
//   abort             : cancel an active load
//   we/wr_addr/wr_data: RAM write port (address/data hold when we=0)
//   busy              : a load is in progress
//   done              : one-cycle pulse after the final write
//   err               : sticky geometry error, cleared by the next start
// -----------------------------------------------------------------------------
module sprite_ram_loader
    import tank_gfx_pkg::*;
#(
    parameter int unsigned ADDR_W = SPRITE_ADDR_W,
    parameter int unsigned DATA_W = SPRITE_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        width_log2,
    input  logic [9:0]        width_px,
    input  logic [9:0]        height_px,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              abort,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Wide enough that base + ((height-1) << width_log2) + width - 1 cannot
    // wrap for any 4-bit width_log2, so the bounds test is exact.
    localparam int unsigned CHK_W = ADDR_W + DIM_W + 16;

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        log2_q, log2_d;
    logic [DIM_W-1:0]  wpx_q, wpx_d;
    logic [DIM_W-1:0]  hpx_q, hpx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              start_ok;
    logic              accept;
    logic              geom_bad;
    logic [16:0]       pitch;
    logic [CHK_W-1:0]  end_addr;
    logic [DIM_W-1:0]  cur_x, cur_y;
    logic              cur_last;
    logic [ADDR_W-1:0] pix_addr;

    sprite_xy_counter u_xy (
        .Clk       (Clk),
        .Reset     (Reset),
        .step      (we_d),
        .clear     (start_ok),
        .width_px  (wpx_q),
        .height_px (hpx_q),
        .x         (cur_x),
        .y         (cur_y),
        .last      (cur_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: state_d = (abort || geom_bad) ? ST_IDLE : ST_LOAD;
            ST_LOAD: begin
                if (abort)                    state_d = ST_IDLE;
                else if (accept && cur_last)  state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pix_ready = (state_q == ST_LOAD);
        busy      = (state_q != ST_IDLE);
        start_ok  = (state_q == ST_IDLE) && start;
        accept    = pix_ready && pix_valid;
    end

    // Geometry validation on the latched request, used during CHECK.
    always_comb begin
        pitch    = 17'd1 << log2_q;
        end_addr = CHK_W'(base_q)
                 + (CHK_W'(hpx_q - DIM_ONE) << log2_q)
                 + CHK_W'(wpx_q) - CHK_W'(1);
        geom_bad = (wpx_q == '0) || (hpx_q == '0)
                || (log2_q > MAX_WIDTH_LOG2)
                || (17'(wpx_q) > pitch)
                || (end_addr >= (CHK_W'(1) << ADDR_W));
        pix_addr = base_q + ADDR_W'(cur_x) + (ADDR_W'(cur_y) << log2_q);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        base_d    = base_q;
        log2_d    = log2_q;
        wpx_d     = wpx_q;
        hpx_d     = hpx_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;

        if (start_ok) begin
            base_d = base_addr;
            log2_d = width_log2;
            wpx_d  = width_px;
            hpx_d  = height_px;
        end

        // A beat accepted in the same cycle as abort is dropped.
        we_d = accept && !abort;
        if (we_d) begin
            wr_addr_d = pix_addr;
            wr_data_d = pix_data;
        end

        // FLUSH is the cycle the final write is visible; done follows it.
        done_d = (state_q == ST_FLUSH);

        if (start_ok)
            err_d = 1'b0;
        else if ((state_q == ST_CHECK) && !abort && geom_bad)
            err_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            base_q    <= '0;
            log2_q    <= '0;
            wpx_q     <= '0;
            hpx_q     <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            base_q    <= base_d;
            log2_q    <= log2_d;
            wpx_q     <= wpx_d;
            hpx_q     <= hpx_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign we      = we_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_sprite_ram_loader
// Randomized self-checking bench. The reference model derives every expected
// write from the sprite geometry: pixel number k lands at
// base + (k % width) + ((k / width) << width_log2), one cycle after acceptance.
// -----------------------------------------------------------------------------
module tb_sprite_ram_loader;
    import tank_gfx_pkg::*;

    localparam int AW = 19;
    localparam int DW = 24;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [3:0]    width_log2;
    logic [9:0]    width_px;
    logic [9:0]    height_px;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          abort;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the RAM port's held address/data and a count of observed writes.
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    int            writes_seen = 0;

    sprite_ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .base_addr  (base_addr),
        .width_log2 (width_log2),
        .width_px   (width_px),
        .height_px  (height_px),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .abort      (abort),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, then check the RAM write port against the model.
    task automatic tick(input bit exp_we, input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_data);
        @(posedge Clk);
        #1;
        if (exp_we) begin
            last_addr = exp_addr;
            last_data = exp_data;
        end
        check("we", we, exp_we);
        check("wr_addr", wr_addr, last_addr);
        check("wr_data", wr_data, last_data);
        if (we) writes_seen++;
    endtask

    // vmode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
    // cut_kind: 0 none, 1 abort, 2 reset, applied with the beat after 'cut'
    // beats have been accepted. glitch_k: beat index during which a stray
    // start with a different base is driven (-1 for none).
    task automatic run_load(input logic [AW-1:0] base, input int l2, input int w, input int h,
                            input int vmode, input int cut, input int cut_kind, input int glitch_k);
        bit            bad, v, cut_now, acc, was_cut;
        int            total, k, cyc, limit;
        longint        end_addr;
        logic [DW-1:0] px;
        logic [AW-1:0] ea;

        end_addr = longint'(base) + ((longint'(h) - 1) << l2) + longint'(w) - 1;
        bad   = (w == 0) || (h == 0) || (l2 > 9) || (w > (1 << l2))
             || (end_addr >= (longint'(1) << AW));
        total = bad ? 0 : w * h;
        limit = 4 * total + 50;
        writes_seen = 0;
        was_cut = 1'b0;

        // Request; a simultaneous abort in IDLE must not block the start.
        start      = 1'b1;
        abort      = 1'($urandom_range(0, 1));
        base_addr  = base;
        width_log2 = 4'(l2);
        width_px   = 10'(w);
        height_px  = 10'(h);
        pix_valid  = 1'b0;
        tick(1'b0, '0, '0);
        start = 1'b0;
        abort = 1'b0;
        check("busy_in_check", busy, 1);
        check("ready_in_check", pix_ready, 0);
        check("err_cleared_by_start", err, 0);
        tick(1'b0, '0, '0);

        if (bad) begin
            for (int i = 0; i < 3; i++) begin
                check("err_sticky", err, 1);
                check("busy_after_err", busy, 0);
                check("ready_after_err", pix_ready, 0);
                check("no_done_on_err", done, 0);
                tick(1'b0, '0, '0);
            end
            check("writes_on_err", writes_seen, 0);
            return;
        end

        k   = 0;
        cyc = 0;
        while (k < total) begin
            check("ready_in_load", pix_ready, 1);
            check("busy_in_load", busy, 1);
            check("no_done_in_load", done, 0);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            cut_now = (cut_kind != 0) && (k == cut) && v;
            px = DW'($urandom);
            if ($urandom_range(0, 7) == 0) px = TRANSPARENT_KEY;
            pix_valid = v;
            pix_data  = px;
            abort     = cut_now && (cut_kind == 1);
            Reset     = cut_now && (cut_kind == 2);
            start     = (k == glitch_k);
            base_addr = start ? (base ^ AW'('h40)) : base;
            acc = v && !cut_now;
            ea  = AW'(longint'(base) + (k % w) + (longint'(k / w) << l2));
            if (cut_now && cut_kind == 2) begin
                last_addr = '0;
                last_data = '0;
            end
            tick(acc, ea, px);
            cyc++;
            if (cut_now) begin
                was_cut = 1'b1;
                break;
            end
            if (acc) k++;
            if (cyc > limit) begin
                check("load_timeout", k, total);
                break;
            end
        end
        pix_valid = 1'b0;
        abort     = 1'b0;
        Reset     = 1'b0;
        start     = 1'b0;
        base_addr = base;

        if (was_cut) begin
            check("busy_after_cut", busy, 0);
            check("ready_after_cut", pix_ready, 0);
            check("err_after_cut", err, 0);
            for (int i = 0; i < 3; i++) begin
                check("no_done_after_cut", done, 0);
                tick(1'b0, '0, '0);
            end
            check("writes_after_cut", writes_seen, cut);
        end else if (k == total) begin
            check("busy_in_flush", busy, 1);
            check("ready_in_flush", pix_ready, 0);
            check("no_done_in_flush", done, 0);
            tick(1'b0, '0, '0);
            check("done_pulse", done, 1);
            check("busy_after_done", busy, 0);
            check("ready_in_idle", pix_ready, 0);
            check("err_after_load", err, 0);
            tick(1'b0, '0, '0);
            check("done_one_cycle", done, 0);
            check("write_count", writes_seen, total);
        end
    endtask

    initial begin
        Reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        width_log2 = '0;
        width_px   = '0;
        height_px  = '0;
        pix_data   = '0;
        pix_valid  = 1'b0;
        tick(1'b0, '0, '0);
        tick(1'b0, '0, '0);
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        Reset = 1'b0;
        tick(1'b0, '0, '0);
        check("idle_busy", busy, 0);

        // 32x32 at 0x100, pitch 32, continuous stream.
        run_load(AW'('h100), 5, 32, 32, 0, -1, 0, -1);
        // 40x2 at 0, pitch 64, valid toggling.
        run_load(AW'(0), 6, 40, 2, 1, -1, 0, -1);
        // Overruns the top of RAM.
        run_load(AW'('h7FFF0), 5, 32, 1, 0, -1, 0, -1);
        // Pitch exponent out of range, then width wider than pitch.
        run_load(AW'(0), 10, 4, 2, 0, -1, 0, -1);
        run_load(AW'(0), 2, 5, 2, 0, -1, 0, -1);
        // Abort after 10 beats of 8x8, then a full reload.
        run_load(AW'('h2000), 3, 8, 8, 2, 10, 1, -1);
        run_load(AW'('h2000), 3, 8, 8, 0, -1, 0, -1);
        // Reset on beat 5 of 4x4, then a full reload.
        run_load(AW'('h300), 2, 4, 4, 0, 4, 2, -1);
        run_load(AW'('h300), 2, 4, 4, 2, -1, 0, -1);
        // Stray start mid-load with a different base.
        run_load(AW'('h500), 3, 6, 3, 2, -1, 0, 5);
        // Exact fit at the top of RAM.
        run_load(AW'('h7FFE0), 4, 16, 2, 0, -1, 0, -1);

        for (int t = 0; t < 14; t++) begin
            int            l2, w, h, vm, cut, kind;
            logic [AW-1:0] b;
            l2   = $urandom_range(0, 5);
            w    = $urandom_range(1, 1 << l2);
            h    = $urandom_range(1, 6);
            b    = AW'($urandom_range(0, (1 << AW) - 1));
            vm   = $urandom_range(0, 2);
            cut  = -1;
            kind = 0;
            case ($urandom_range(0, 5))
                0:       w = (1 << l2) + 1;
                1:       b = AW'((1 << AW) - $urandom_range(1, 40));
                2: begin
                    kind = 1;
                    cut  = $urandom_range(0, w * h - 1);
                end
                default: ;
            endcase
            run_load(b, l2, w, h, vm, cut, kind, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
